// File: rtl/snn_potential_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_potential_adder : gathers three PE partial sums and an old membrane
// potential per neuron, then adds, thresholds and returns {spike, new MP}.
// Rev 1.0
// ----------------------------------------------------------------------------
module snn_potential_adder #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int OP_WIDTH     = 2,
  parameter int PACKET_WIDTH = 39,
  parameter int ADDER_ADDR   = 2,
  parameter int PE_ADDR0     = 4,
  parameter int PE_ADDR1     = 1,
  parameter int PE_ADDR2     = 0,
  parameter int OP_PSUM      = 2,
  parameter int THRESHOLD    = 64,
  parameter int OFMAP_SIZE   = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    noc_valid,
  output logic                    noc_ready,
  input  logic [PACKET_WIDTH-1:0] noc_pkt,
  input  logic                    mp_valid,
  output logic                    mp_ready,
  input  logic [WIDTH-1:0]        mp_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          out_data,
  output logic [3:0]              out_idx,
  output logic                    busy,
  output logic                    err_pkt
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SUM     = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  localparam int SUM_W = WIDTH + 2;
  localparam int SRC_LSB = ADDR_WIDTH;
  localparam int OP_LSB  = 2 * ADDR_WIDTH;
  localparam int PS_LSB  = 2 * ADDR_WIDTH + OP_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] SELF_A = ADDR_WIDTH'(ADDER_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PE0_A  = ADDR_WIDTH'(PE_ADDR0);
  localparam logic [ADDR_WIDTH-1:0] PE1_A  = ADDR_WIDTH'(PE_ADDR1);
  localparam logic [ADDR_WIDTH-1:0] PE2_A  = ADDR_WIDTH'(PE_ADDR2);
  localparam logic [OP_WIDTH-1:0]   PSUM_OP = OP_WIDTH'(OP_PSUM);
  localparam logic [SUM_W-1:0]      THR     = SUM_W'(THRESHOLD);
  localparam logic [SUM_W-1:0]      MP_MAX  = {2'b00, {WIDTH{1'b1}}};
  localparam logic [3:0]            IDX_LAST = 4'(OFMAP_SIZE - 1);

  logic [1:0]             state_q, state_d;
  logic [2:0]             pe_seen_q, pe_seen_d;
  logic                   mp_seen_q, mp_seen_d;
  logic [WIDTH-1:0]       mp_q, mp_d;
  logic [2:0][WIDTH-1:0]  psum_q, psum_d;
  logic [WIDTH:0]         out_data_q, out_data_d;
  logic [3:0]             out_idx_q, out_idx_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_q, err_d;

  logic [ADDR_WIDTH-1:0]  pkt_dest;
  logic [ADDR_WIDTH-1:0]  pkt_src;
  logic [OP_WIDTH-1:0]    pkt_op;
  logic [WIDTH-1:0]       pkt_psum;
  logic [2:0]             src_hit;
  logic                   pkt_good;
  logic                   noc_fire;
  logic                   mp_fire;
  logic [SUM_W-1:0]       sum;
  logic [WIDTH:0]         result;

  assign pkt_dest = noc_pkt[ADDR_WIDTH-1:0];
  assign pkt_src  = noc_pkt[SRC_LSB +: ADDR_WIDTH];
  assign pkt_op   = noc_pkt[OP_LSB +: OP_WIDTH];
  assign pkt_psum = noc_pkt[PS_LSB +: WIDTH];

  always_comb begin
    src_hit = 3'b000;
    if (pkt_src == PE0_A)      src_hit = 3'b001;
    else if (pkt_src == PE1_A) src_hit = 3'b010;
    else if (pkt_src == PE2_A) src_hit = 3'b100;
  end

  // A packet from a PE already heard this neuron waits for the next neuron.
  assign noc_ready = (state_q == S_COLLECT) && ((src_hit & pe_seen_q) == 3'b000);
  assign mp_ready  = (state_q == S_COLLECT) && !mp_seen_q;
  assign noc_fire  = noc_valid && noc_ready;
  assign mp_fire   = mp_valid && mp_ready;
  assign pkt_good  = (pkt_dest == SELF_A) && (pkt_op == PSUM_OP) && (src_hit != 3'b000);

  assign sum = SUM_W'(mp_q) + SUM_W'(psum_q[0]) + SUM_W'(psum_q[1]) + SUM_W'(psum_q[2]);

  always_comb begin
    if (sum >= THR)        result = {1'b1, {WIDTH{1'b0}}};
    else if (sum > MP_MAX) result = {1'b0, {WIDTH{1'b1}}};
    else                   result = {1'b0, sum[WIDTH-1:0]};
  end

  always_comb begin
    state_d     = state_q;
    pe_seen_d   = pe_seen_q;
    mp_seen_d   = mp_seen_q;
    mp_d        = mp_q;
    psum_d      = psum_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (noc_fire) begin
      if (pkt_good) begin
        for (int k = 0; k < 3; k++) begin
          if (src_hit[k]) psum_d[k] = pkt_psum;
        end
        pe_seen_d = pe_seen_q | src_hit;
      end else begin
        err_d = 1'b1;
      end
    end

    if (mp_fire) begin
      mp_d      = mp_in;
      mp_seen_d = 1'b1;
    end

    case (state_q)
      S_COLLECT: begin
        if ((pe_seen_q == 3'b111) && mp_seen_q) state_d = S_SUM;
      end
      S_SUM: begin
        out_data_d  = result;
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pe_seen_d   = 3'b000;
          mp_seen_d   = 1'b0;
          out_idx_d   = (out_idx_q == IDX_LAST) ? 4'd0 : out_idx_q + 4'd1;
          state_d     = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      pe_seen_q   <= 3'b000;
      mp_seen_q   <= 1'b0;
      mp_q        <= '0;
      psum_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= 4'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pe_seen_q   <= pe_seen_d;
      mp_seen_q   <= mp_seen_d;
      mp_q        <= mp_d;
      psum_q      <= psum_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign err_pkt   = err_q;
  assign busy      = (pe_seen_q != 3'b000) || mp_seen_q || (state_q != S_COLLECT);

endmodule
`default_nettype wire
